// File: rtl/simd_lane_sequencer.sv
// simd_lane_sequencer: runs one vector ALU op per wavefront on NUM_LANES physical
// lanes, sweeping WF_SIZE/NUM_LANES passes. Results are buffered and written back
// once, with a stall handshake from the writeback sink. Compare ops produce VCC.
module simd_lane_sequencer #(
  parameter int WF_SIZE   = 64,
  parameter int NUM_LANES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_alu_select,
  input  logic [5:0]              issue_wfid,
  input  logic [3:0]              issue_op,
  input  logic [9:0]              issue_dest_addr,
  input  logic [WF_SIZE*32-1:0]   vgpr_source1_data,
  input  logic [WF_SIZE*32-1:0]   vgpr_source2_data,
  input  logic [WF_SIZE-1:0]      exec_rd_exec_value,
  input  logic                    wb_stall,
  output logic                    issue_alu_ready,
  output logic                    vgpr_wr_en,
  output logic [9:0]              vgpr_dest_addr,
  output logic [WF_SIZE*32-1:0]   vgpr_dest_data,
  output logic [WF_SIZE-1:0]      vgpr_wr_mask,
  output logic                    exec_wr_vcc_en,
  output logic [5:0]              exec_wr_vcc_wfid,
  output logic [WF_SIZE-1:0]      exec_wr_vcc_value,
  output logic                    vgpr_instr_done,
  output logic [5:0]              vgpr_instr_done_wfid
);

  localparam int PASSES = WF_SIZE / NUM_LANES;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_MOV    = 4'd5;
  localparam logic [3:0] OP_MAX_U  = 4'd6;
  localparam logic [3:0] OP_MIN_U  = 4'd7;
  localparam logic [3:0] OP_CMP_LT = 4'd8;
  localparam logic [3:0] OP_CMP_EQ = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_e;

  state_e                  state_q, state_d;
  logic [PASS_W-1:0]       pass_q, pass_d;
  logic [5:0]              wfid_q;
  logic [3:0]              op_q;
  logic [9:0]              dest_q;
  logic [WF_SIZE*32-1:0]   a_q, b_q;
  logic [WF_SIZE-1:0]      exec_q;
  logic [WF_SIZE*32-1:0]   res_q, res_d;
  logic [WF_SIZE-1:0]      vcc_q, vcc_d;
  int                      thread_base;
  logic                    issue_fire;
  logic                    wb_fire;
  logic                    is_vgpr_op;
  logic                    is_cmp_op;

  // Per-thread 32-bit unsigned ALU result; compare and undefined ops yield 0.
  function automatic logic [31:0] alu(input logic [3:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_MOV:   return b;
      OP_MAX_U: return (a > b) ? a : b;
      OP_MIN_U: return (a < b) ? a : b;
      default:  return 32'h0;
    endcase
  endfunction

  // Per-thread compare bit; non-compare ops never set VCC.
  function automatic logic cmp(input logic [3:0] op,
                               input logic [31:0] a,
                               input logic [31:0] b);
    case (op)
      OP_CMP_LT: return a < b;
      OP_CMP_EQ: return a == b;
      default:   return 1'b0;
    endcase
  endfunction

  assign issue_fire = (state_q == ST_IDLE) && issue_alu_select;
  assign wb_fire    = (state_q == ST_WB) && !wb_stall;
  assign is_vgpr_op = (op_q <= OP_MIN_U);
  assign is_cmp_op  = (op_q == OP_CMP_LT) || (op_q == OP_CMP_EQ);

  // Next-state logic: IDLE -> EXEC for PASSES cycles -> WB until the sink accepts.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_alu_select) begin
          state_d = ST_EXEC;
          pass_d  = '0;
        end
      end
      ST_EXEC: begin
        if (pass_q == LAST_PASS) begin
          state_d = ST_WB;
          pass_d  = '0;
        end else begin
          pass_d = pass_q + PASS_W'(1);
        end
      end
      ST_WB: begin
        if (!wb_stall) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pass_d  = '0;
      end
    endcase
  end

  // State and pass counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= ST_IDLE;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  // Lane datapath: compute this pass's slice of threads into the result/VCC buffers.
  always_comb begin
    res_d       = res_q;
    vcc_d       = vcc_q;
    thread_base = int'(pass_q) * NUM_LANES;
    if (state_q == ST_EXEC) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (exec_q[thread_base + l]) begin
          res_d[(thread_base + l)*32 +: 32] = alu(op_q, a_q[(thread_base + l)*32 +: 32],
                                                  b_q[(thread_base + l)*32 +: 32]);
          vcc_d[thread_base + l] = cmp(op_q, a_q[(thread_base + l)*32 +: 32],
                                       b_q[(thread_base + l)*32 +: 32]);
        end else begin
          res_d[(thread_base + l)*32 +: 32] = 32'h0;
          vcc_d[thread_base + l]            = 1'b0;
        end
      end
    end
  end

  // Operand capture on issue and result/VCC buffer update.
  always_ff @(posedge clk) begin
    // NOTE: the wide operand/result buffers are reset too, so outputs read 0 after reset.
    if (rst) begin
      wfid_q <= '0;
      op_q   <= '0;
      dest_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      exec_q <= '0;
      res_q  <= '0;
      vcc_q  <= '0;
    end else begin
      if (issue_fire) begin
        wfid_q <= issue_wfid;
        op_q   <= issue_op;
        dest_q <= issue_dest_addr;
        a_q    <= vgpr_source1_data;
        b_q    <= vgpr_source2_data;
        exec_q <= exec_rd_exec_value;
      end
      res_q <= res_d;
      vcc_q <= vcc_d;
    end
  end

  assign issue_alu_ready      = (state_q == ST_IDLE);
  assign vgpr_wr_en           = wb_fire && is_vgpr_op;
  assign exec_wr_vcc_en       = wb_fire && is_cmp_op;
  assign vgpr_instr_done      = wb_fire;
  assign vgpr_dest_addr       = dest_q;
  assign vgpr_dest_data       = res_q;
  assign vgpr_wr_mask         = is_vgpr_op ? exec_q : '0;
  assign exec_wr_vcc_wfid     = wfid_q;
  assign exec_wr_vcc_value    = vcc_q;
  assign vgpr_instr_done_wfid = wfid_q;

endmodule

// File: tb/tb_simd_lane_sequencer.sv
// Testbench for simd_lane_sequencer: table vectors, randomized ops against a
// thread-level reference model, and hand sequences for stall, reset, back-to-back
// issue and the NUM_LANES sweep.
module tb_simd_lane_sequencer;

  localparam int WF     = 64;
  localparam int DW     = WF * 32;
  localparam int PASSES = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            issue_sel, sel1, sel64;
  logic [5:0]      wfid;
  logic [3:0]      op;
  logic [9:0]      dest;
  logic [DW-1:0]   src1, src2;
  logic [WF-1:0]   exec_val;
  logic            wb_stall;

  logic            ready, wr_en, vcc_en, done;
  logic [9:0]      dest_addr;
  logic [DW-1:0]   dest_data;
  logic [WF-1:0]   wr_mask, vcc_value;
  logic [5:0]      vcc_wfid, done_wfid;

  logic            s_ready [2];
  logic            s_wr_en [2];
  logic            s_vcc_en [2];
  logic            s_done [2];
  logic [9:0]      s_addr [2];
  logic [DW-1:0]   s_data [2];
  logic [WF-1:0]   s_mask [2];
  logic [WF-1:0]   s_vcc [2];
  logic [5:0]      s_vwf [2];
  logic [5:0]      s_dwf [2];

  simd_lane_sequencer #(.WF_SIZE(WF), .NUM_LANES(16)) dut (
    .clk(clk), .rst(rst), .issue_alu_select(issue_sel), .issue_wfid(wfid),
    .issue_op(op), .issue_dest_addr(dest), .vgpr_source1_data(src1),
    .vgpr_source2_data(src2), .exec_rd_exec_value(exec_val), .wb_stall(wb_stall),
    .issue_alu_ready(ready), .vgpr_wr_en(wr_en), .vgpr_dest_addr(dest_addr),
    .vgpr_dest_data(dest_data), .vgpr_wr_mask(wr_mask), .exec_wr_vcc_en(vcc_en),
    .exec_wr_vcc_wfid(vcc_wfid), .exec_wr_vcc_value(vcc_value),
    .vgpr_instr_done(done), .vgpr_instr_done_wfid(done_wfid));

  simd_lane_sequencer #(.WF_SIZE(WF), .NUM_LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .issue_alu_select(sel1), .issue_wfid(wfid),
    .issue_op(op), .issue_dest_addr(dest), .vgpr_source1_data(src1),
    .vgpr_source2_data(src2), .exec_rd_exec_value(exec_val), .wb_stall(wb_stall),
    .issue_alu_ready(s_ready[0]), .vgpr_wr_en(s_wr_en[0]), .vgpr_dest_addr(s_addr[0]),
    .vgpr_dest_data(s_data[0]), .vgpr_wr_mask(s_mask[0]), .exec_wr_vcc_en(s_vcc_en[0]),
    .exec_wr_vcc_wfid(s_vwf[0]), .exec_wr_vcc_value(s_vcc[0]),
    .vgpr_instr_done(s_done[0]), .vgpr_instr_done_wfid(s_dwf[0]));

  simd_lane_sequencer #(.WF_SIZE(WF), .NUM_LANES(64)) dut_l64 (
    .clk(clk), .rst(rst), .issue_alu_select(sel64), .issue_wfid(wfid),
    .issue_op(op), .issue_dest_addr(dest), .vgpr_source1_data(src1),
    .vgpr_source2_data(src2), .exec_rd_exec_value(exec_val), .wb_stall(wb_stall),
    .issue_alu_ready(s_ready[1]), .vgpr_wr_en(s_wr_en[1]), .vgpr_dest_addr(s_addr[1]),
    .vgpr_dest_data(s_data[1]), .vgpr_wr_mask(s_mask[1]), .exec_wr_vcc_en(s_vcc_en[1]),
    .exec_wr_vcc_wfid(s_vwf[1]), .exec_wr_vcc_value(s_vcc[1]),
    .vgpr_instr_done(s_done[1]), .vgpr_instr_done_wfid(s_dwf[1]));

  typedef struct {
    string         name;
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [WF-1:0] ex;
    logic [DW-1:0] exp_d;
    logic [WF-1:0] exp_v;
    bit            exp_we;
    bit            exp_ve;
  } vec_t;

  vec_t tbl [7];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int first;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      first = 0;
      for (int t = WF - 1; t >= 0; t--)
        if (act[t*32 +: 32] !== exp[t*32 +: 32]) first = t;
      $display("FAIL %s: thread %0d got %h expected %h", name, first,
               act[first*32 +: 32], exp[first*32 +: 32]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int t = 0; t < WF; t++) v[t*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: per-thread arithmetic straight from the op table.
  function automatic void model(input logic [3:0] mop, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [WF-1:0] ex,
                                output logic [DW-1:0] d, output logic [WF-1:0] v,
                                output bit we, output bit ve);
    longint m32 = 64'h1_0000_0000;
    longint ai, bi, r;
    d  = '0;
    v  = '0;
    we = (mop <= 4'd7);
    ve = (mop == 4'd8) || (mop == 4'd9);
    for (int t = 0; t < WF; t++) begin
      ai = longint'(a[t*32 +: 32]);
      bi = longint'(b[t*32 +: 32]);
      r  = 0;
      if (ex[t]) begin
        case (mop)
          4'd0: r = (ai + bi) % m32;
          4'd1: r = (ai - bi + m32) % m32;
          4'd2: r = ai & bi;
          4'd3: r = ai | bi;
          4'd4: r = ai ^ bi;
          4'd5: r = bi;
          4'd6: r = (ai > bi) ? ai : bi;
          4'd7: r = (ai < bi) ? ai : bi;
          4'd8: v[t] = (ai < bi);
          4'd9: v[t] = (ai == bi);
          default: r = 0;
        endcase
      end
      d[t*32 +: 32] = 32'(r);
    end
  endfunction

  // Issue one op on the main DUT, wait for completion and compare everything.
  task automatic run_and_check(input string name, input logic [3:0] iop,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [WF-1:0] ex, input logic [5:0] iwf,
                               input logic [9:0] idst, input logic [DW-1:0] exp_d,
                               input logic [WF-1:0] exp_v, input bit exp_we,
                               input bit exp_ve);
    int cyc;
    bit early;
    check({name, "_ready_pre"}, 64'(ready), 64'd1);
    wfid = iwf; op = iop; dest = idst; src1 = a; src2 = b; exec_val = ex;
    issue_sel = 1'b1;
    tick();
    issue_sel = 1'b0;
    src1 = rand_vec(); src2 = rand_vec(); exec_val = {$urandom, $urandom};
    op = 4'($urandom); wfid = 6'($urandom); dest = 10'($urandom);
    cyc = 1;
    early = 1'b0;
    while (!done && cyc < 40) begin
      if (wr_en || vcc_en || ready) early = 1'b1;
      tick();
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(PASSES + 1));
    check({name, "_early_strobe"}, 64'(early), 64'd0);
    check({name, "_wr_en"}, 64'(wr_en), 64'(exp_we));
    check({name, "_vcc_en"}, 64'(vcc_en), 64'(exp_ve));
    check({name, "_done_wfid"}, 64'(done_wfid), 64'(iwf));
    if (exp_we) begin
      check({name, "_addr"}, 64'(dest_addr), 64'(idst));
      check({name, "_mask"}, wr_mask, ex);
      check_data({name, "_data"}, dest_data, exp_d);
    end
    if (exp_ve) begin
      check({name, "_vcc"}, vcc_value, exp_v);
      check({name, "_vcc_wfid"}, 64'(vcc_wfid), 64'(iwf));
    end
    tick();
    check({name, "_ready_post"}, 64'(ready), 64'd1);
    check({name, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] ra, rb, ed;
    logic [WF-1:0] rex, ev;
    bit            ewe, eve;
    int            cyc, n_done;
    int            dcyc [2];
    int            dwf [2];
    int            first_done [3];
    bit            wrote [3];

    // Table vectors built from the op definitions.
    for (int i = 0; i < 7; i++) begin
      tbl[i].a = '0; tbl[i].b = '0; tbl[i].exp_d = '0; tbl[i].exp_v = '0;
    end
    tbl[0].name = "add_wrap"; tbl[0].op = 4'd0; tbl[0].ex = '1;
    tbl[0].exp_we = 1; tbl[0].exp_ve = 0;
    tbl[1].name = "cmp_lt"; tbl[1].op = 4'd8; tbl[1].ex = 64'h00000000_FFFF0000;
    tbl[1].exp_v = 64'h00000000_FFFF0000; tbl[1].exp_we = 0; tbl[1].exp_ve = 1;
    tbl[2].name = "mov_half"; tbl[2].op = 4'd5; tbl[2].ex = 64'hAAAA_AAAA_AAAA_AAAA;
    tbl[2].exp_we = 1; tbl[2].exp_ve = 0;
    tbl[3].name = "undef_op"; tbl[3].op = 4'd12; tbl[3].ex = '1;
    tbl[3].exp_we = 0; tbl[3].exp_ve = 0;
    tbl[4].name = "exec_zero"; tbl[4].op = 4'd0; tbl[4].ex = '0;
    tbl[4].exp_we = 1; tbl[4].exp_ve = 0;
    tbl[5].name = "cmp_eq"; tbl[5].op = 4'd9; tbl[5].ex = '1;
    tbl[5].exp_v = 64'h5555_5555_5555_5555; tbl[5].exp_we = 0; tbl[5].exp_ve = 1;
    tbl[6].name = "max_u"; tbl[6].op = 4'd6; tbl[6].ex = '1;
    tbl[6].exp_we = 1; tbl[6].exp_ve = 0;
    for (int t = 0; t < WF; t++) begin
      tbl[0].a[t*32 +: 32] = 32'(t);
      tbl[0].b[t*32 +: 32] = 32'hFFFF_FFFF;
      tbl[0].exp_d[t*32 +: 32] = 32'(t) - 32'd1;
      tbl[1].a[t*32 +: 32] = 32'(t);
      tbl[1].b[t*32 +: 32] = 32'd32;
      tbl[2].a[t*32 +: 32] = 32'hDEAD_0000 + 32'(t);
      tbl[2].b[t*32 +: 32] = 32'(3 * t);
      tbl[2].exp_d[t*32 +: 32] = (t % 2 == 1) ? 32'(3 * t) : 32'h0;
      tbl[3].a[t*32 +: 32] = 32'(t);
      tbl[3].b[t*32 +: 32] = 32'(t);
      tbl[4].a[t*32 +: 32] = 32'(t + 100);
      tbl[4].b[t*32 +: 32] = 32'(7);
      tbl[5].a[t*32 +: 32] = 32'(t);
      tbl[5].b[t*32 +: 32] = (t % 2 == 0) ? 32'(t) : 32'h0;
      tbl[6].a[t*32 +: 32] = 32'(t);
      tbl[6].b[t*32 +: 32] = 32'h8000_0000;
      tbl[6].exp_d[t*32 +: 32] = 32'h8000_0000;
    end

    rst = 1'b1; issue_sel = 1'b0; sel1 = 1'b0; sel64 = 1'b0; wb_stall = 1'b0;
    wfid = '0; op = '0; dest = '0; src1 = '0; src2 = '0; exec_val = '0;
    tick();
    tick();
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_vcc_en", 64'(vcc_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mask", wr_mask, 64'd0);
    check("rst_vcc", vcc_value, 64'd0);
    check_data("rst_data", dest_data, '0);
    check("rst_ready_l1", 64'(s_ready[0]), 64'd1);
    check("rst_ready_l64", 64'(s_ready[1]), 64'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_and_check(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ex,
                    6'(i + 1), 10'(10'h100 + i), tbl[i].exp_d, tbl[i].exp_v,
                    tbl[i].exp_we, tbl[i].exp_ve);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      ra = rand_vec();
      rb = rand_vec();
      for (int t = 0; t < WF; t++)
        if ($urandom_range(0, 3) == 0) rb[t*32 +: 32] = ra[t*32 +: 32];
      case ($urandom_range(0, 7))
        0: rex = '0;
        1: rex = '1;
        default: rex = {$urandom, $urandom};
      endcase
      model(rop, ra, rb, rex, ed, ev, ewe, eve);
      run_and_check("rand", rop, ra, rb, rex, 6'($urandom), 10'($urandom),
                    ed, ev, ewe, eve);
    end

    // Writeback stall for three cycles on entering WB.
    ra = rand_vec(); rb = rand_vec(); rex = '1;
    model(4'd0, ra, rb, rex, ed, ev, ewe, eve);
    wfid = 6'd21; op = 4'd0; dest = 10'h2A; src1 = ra; src2 = rb; exec_val = rex;
    issue_sel = 1'b1;
    tick();
    issue_sel = 1'b0;
    wb_stall = 1'b1;
    repeat (PASSES) tick();
    for (int k = 0; k < 3; k++) begin
      check("stall_wr_en", 64'(wr_en), 64'd0);
      check("stall_done", 64'(done), 64'd0);
      check("stall_ready", 64'(ready), 64'd0);
      check_data("stall_data", dest_data, ed);
      issue_sel = 1'b1;
      wfid = 6'd33;
      tick();
    end
    wb_stall = 1'b0;
    issue_sel = 1'b0;
    #1;
    check("stall_release_done", 64'(done), 64'd1);
    check("stall_release_wr_en", 64'(wr_en), 64'd1);
    check("stall_release_wfid", 64'(done_wfid), 64'd21);
    check_data("stall_release_data", dest_data, ed);
    tick();
    check("stall_after_ready", 64'(ready), 64'd1);
    tick();
    check("stall_ignored_select", 64'(ready), 64'd1);
    check("stall_no_extra_done", 64'(done), 64'd0);

    // Reset in the middle of pass 2 aborts the op.
    wfid = 6'd40; op = 4'd4; dest = 10'h33; src1 = rand_vec(); src2 = rand_vec();
    exec_val = '1;
    issue_sel = 1'b1;
    tick();
    issue_sel = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_wr_en", 64'(wr_en), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check_data("midrst_data", dest_data, '0);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || wr_en) n_done++;
      tick();
    end
    check("midrst_no_late_done", 64'(n_done), 64'd0);
    ra = rand_vec(); rb = rand_vec(); rex = {$urandom, $urandom};
    model(4'd1, ra, rb, rex, ed, ev, ewe, eve);
    run_and_check("after_rst", 4'd1, ra, rb, rex, 6'd41, 10'h34, ed, ev, ewe, eve);

    // Back-to-back issue with select held high.
    wfid = 6'd5; op = 4'd3; dest = 10'h50; src1 = rand_vec(); src2 = rand_vec();
    exec_val = '1;
    issue_sel = 1'b1;
    tick();
    wfid = 6'd9;
    cyc = 1;
    n_done = 0;
    dcyc[0] = 0; dcyc[1] = 0; dwf[0] = 0; dwf[1] = 0;
    while (n_done < 2 && cyc < 30) begin
      if (done) begin
        dcyc[n_done] = cyc;
        dwf[n_done]  = int'(done_wfid);
        n_done++;
      end
      if (cyc == PASSES + 2) check("b2b_ready", 64'(ready), 64'd1);
      tick();
      if (cyc == PASSES + 2) issue_sel = 1'b0;
      cyc++;
    end
    check("b2b_first_cycle", 64'(dcyc[0]), 64'(PASSES + 1));
    check("b2b_second_cycle", 64'(dcyc[1]), 64'(2 * PASSES + 3));
    check("b2b_first_wfid", 64'(dwf[0]), 64'd5);
    check("b2b_second_wfid", 64'(dwf[1]), 64'd9);
    check("b2b_idle_after", 64'(ready), 64'd1);

    // NUM_LANES sweep {16, 1, 64} with undefined op 12.
    op = 4'd12; wfid = 6'd17; dest = 10'h77; src1 = rand_vec(); src2 = rand_vec();
    exec_val = '1;
    issue_sel = 1'b1; sel1 = 1'b1; sel64 = 1'b1;
    tick();
    issue_sel = 1'b0; sel1 = 1'b0; sel64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      first_done[i] = 0;
      wrote[i] = 1'b0;
    end
    for (int c = 1; c < 80; c++) begin
      if (done && first_done[0] == 0) first_done[0] = c;
      if (s_done[0] && first_done[1] == 0) first_done[1] = c;
      if (s_done[1] && first_done[2] == 0) first_done[2] = c;
      if (wr_en || vcc_en) wrote[0] = 1'b1;
      if (s_wr_en[0] || s_vcc_en[0]) wrote[1] = 1'b1;
      if (s_wr_en[1] || s_vcc_en[1]) wrote[2] = 1'b1;
      tick();
    end
    check("sweep16_done_cycle", 64'(first_done[0]), 64'd5);
    check("sweep1_done_cycle", 64'(first_done[1]), 64'd65);
    check("sweep64_done_cycle", 64'(first_done[2]), 64'd2);
    check("sweep16_no_write", 64'(wrote[0]), 64'd0);
    check("sweep1_no_write", 64'(wrote[1]), 64'd0);
    check("sweep64_no_write", 64'(wrote[2]), 64'd0);
    check("sweep1_ready_end", 64'(s_ready[0]), 64'd1);
    check("sweep64_ready_end", 64'(s_ready[1]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
